// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract built by time-multiplexing one 4-bit ripple-carry slice,
// one nibble per clock (LSB first), with valid/ready handshakes on both sides.

module ripple_carry_4_bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c_in,
    output logic [3:0] o_s,
    output logic       o_c_out
);
    logic [4:0] w_carry;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_carry    = '0;
        o_s        = '0;
        w_carry[0] = i_c_in;
        for (int i = 0; i < 4; i++) begin
            o_s[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_c_out = w_carry[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;

    logic [3:0] w_a_nib;
    logic [3:0] w_b_nib;
    logic [3:0] w_s_nib;
    logic       w_slice_carry;
    logic       w_accept;
    logic       w_last;

    assign w_a_nib  = r_a[4*r_idx +: 4];
    assign w_b_nib  = r_b[4*r_idx +: 4];
    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_idx == LAST_IDX);

    ripple_carry_4_bit u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_c_in (r_carry),
        .o_s    (w_s_nib),
        .o_c_out(w_slice_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next_state = S_RUN;
            S_RUN:   if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // NOTE: operand registers are reset too, so nothing in the datapath powers up unknown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        // Subtract is a + ~b + 1; the +1 rides in as the first carry.
                        r_b     <= op_sub ? ~b : b;
                        r_carry <= op_sub ? 1'b1 : c_in;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[4*r_idx +: 4] <= w_s_nib;
                    r_carry             <= w_slice_carry;
                    if (w_last) begin
                        r_c_out <= w_slice_carry;
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s_nib[3] != r_a[WIDTH-1]);
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16): directed cases, randomized
// operations against an arithmetic model, backpressure, back-to-back and mid-run reset.

module tb_nibble_serial_add_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .op_sub   (op_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic, result packed as {sum, c_out, ovf}.
    function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                           input logic cin, input logic sub);
        int ua, ub, sa, sb, ures, sres;
        logic [W-1:0] s;
        logic co, ov;
        ua = int'(xa);
        ub = int'(xb);
        sa = int'($signed(xa));
        sb = int'($signed(xb));
        if (sub) begin
            ures = ua - ub;
            sres = sa - sb;
            co   = (ua >= ub);
        end else begin
            ures = ua + ub + int'(cin);
            sres = sa + sb + int'(cin);
            co   = (ures > 65535);
        end
        s  = ures[W-1:0];
        ov = (sres > 32767) || (sres < -32768);
        return {s, co, ov};
    endfunction

    // Drives one operation from posedge+1; returns the result and cycles from accept to out_valid.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic cin,
                          input logic sub, input int hold, output logic [W+1:0] res, output int lat);
        int n;
        a = xa; b = xb; c_in = cin; op_sub = sub; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            in_valid = 1'b0; res = 'x; lat = -1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        lat = out_valid ? n : -1;
        res = {sum, c_out, ovf};
        if (out_valid) begin
            repeat (hold) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL reset_handshake: got in_ready/out_valid=%b want 10", {in_ready, out_valid});
        end
        total++;
        if ({sum, c_out, ovf} !== '0) begin
            bad++; $display("FAIL reset_outputs: got sum=%h c_out=%b ovf=%b want 0/0/0", sum, c_out, ovf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W+1:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t v[6];
        logic [W+1:0] res;
        int lat;
        v[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 1'b0, 1'b0}};
        v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0}};
        v[2] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, {16'h0001, 1'b1, 1'b0}};
        v[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1}};
        v[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1}};
        v[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].b, v[i].cin, v[i].sub, 0, res, lat);
            total++;
            if (res !== v[i].exp) begin
                bad++; $display("FAIL directed_%0d result: got {sum,c,v}=%h want %h", i, res, v[i].exp);
            end
            total++;
            if (lat != 4) begin
                bad++; $display("FAIL directed_%0d latency: got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] xa, xb;
        logic cin, sub;
        logic [W+1:0] res, exp;
        int lat;
        for (int i = 0; i < 24; i++) begin
            xa  = W'($urandom);
            xb  = W'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            exp = model(xa, xb, cin, sub);
            run_op(xa, xb, cin, sub, $urandom_range(0, 3), res, lat);
            total++;
            if (res !== exp) begin
                bad++; $display("FAIL random_%0d a=%h b=%h cin=%b sub=%b: got %h want %h", i, xa, xb, cin, sub, res, exp);
            end
            total++;
            if (lat != 4) begin
                bad++; $display("FAIL random_%0d latency: got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] exp;
        int n;
        exp = model(16'h1111, 16'h2222, 1'b0, 1'b0);
        a = 16'h1111; b = 16'h2222; c_in = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        // Busy: foreign operands stay offered through RUN and DONE.
        a = 16'hAAAA; b = 16'h5555; op_sub = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if (!out_valid) begin
            bad++; $display("FAIL bp_timeout: got out_valid=%b want 1 within 20 cycles", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, in_ready, sum, c_out, ovf} !== {2'b10, exp}) begin
                bad++; $display("FAIL bp_hold_%0d: got v/r=%b%b res=%h want 10 %h", i, out_valid, in_ready, {sum, c_out, ovf}, exp);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++; $display("FAIL bp_release: got in_ready/out_valid=%b want 10", {in_ready, out_valid});
        end
        // out_ready stays high in IDLE: must be ignored, outputs keep the last result.
        @(posedge clk); #1;
        total++;
        if ({in_ready, out_valid, sum, c_out, ovf} !== {2'b10, exp}) begin
            bad++; $display("FAIL bp_held_idle: got r/v=%b%b res=%h want 10 %h", in_ready, out_valid, {sum, c_out, ovf}, exp);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xa[4], xb[4];
        logic sub[4];
        int t_acc[4];
        logic [W+1:0] exp;
        int n;
        for (int k = 0; k < 4; k++) begin
            xa[k] = W'($urandom); xb[k] = W'($urandom); sub[k] = 1'($urandom);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        c_in      = 1'b0;
        a = xa[0]; b = xb[0]; op_sub = sub[0];
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            t_acc[k] = cyc;
            exp = model(xa[k], xb[k], 1'b0, sub[k]);
            if (k < 3) begin a = xa[k+1]; b = xb[k+1]; op_sub = sub[k+1]; end
            n = 0;
            while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
            total++;
            if (!out_valid || {sum, c_out, ovf} !== exp) begin
                bad++; $display("FAIL b2b_%0d result: got v=%b res=%h want 1 %h", k, out_valid, {sum, c_out, ovf}, exp);
            end
            if (k > 0) begin
                total++;
                if (t_acc[k] - t_acc[k-1] != 6) begin
                    bad++; $display("FAIL b2b_%0d spacing: got %0d want 6", k, t_acc[k] - t_acc[k-1]);
                end
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W+1:0] res;
        int lat;
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, sum, c_out, ovf} !== {2'b10, 18'h0}) begin
            bad++; $display("FAIL reset_mid_async: got r/v=%b%b res=%h want 10 00000", in_ready, out_valid, {sum, c_out, ovf});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++;
            if ({in_ready, out_valid} !== 2'b10) begin
                bad++; $display("FAIL reset_mid_no_pulse_%0d: got r/v=%b want 10", i, {in_ready, out_valid});
            end
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, res, lat);
        total++;
        if (res !== {16'h0002, 1'b0, 1'b0} || lat != 4) begin
            bad++; $display("FAIL reset_mid_recover: got res=%h lat=%0d want 00008 4", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit ripple-carry slice (ripple_carry_4_bit), one nibble per clock, LSB nibble first.
- Holds the inter-nibble carry in a register and accepts operands over a valid/ready input handshake.
- Returns the result over a valid/ready output handshake.
- Used where a full-width adder is too costly and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of 4 and at least 8; elaboration error otherwise.
- NIBBLES, WIDTH/4: derived count of slice passes. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in, used for add only.
- op_sub  input  1  1 = compute a - b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  final carry. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, nibble index=0, carry reg=0. Operand regs are cleared to 0.
- Reset asserted mid-RUN or mid-DONE aborts immediately. The partial result is discarded; no out_valid pulse follows.
- State IDLE (in_ready=1):
  - On in_valid & in_ready: latch a into A_reg.
  - Latch B_reg = op_sub ? ~b : b.
  - Set carry reg = op_sub ? 1 : c_in; c_in is ignored when op_sub=1.
  - Set idx=0, clear sum, go to RUN.
  - Inputs are sampled only on the accepting edge.
- State RUN (in_ready=0, out_valid=0):
  - Slice inputs are A_reg[4*idx+:4], B_reg[4*idx+:4] and the carry reg.
  - Each edge: sum[4*idx+:4] <= slice sum; carry reg <= slice carry; idx <= idx+1.
  - On the edge where idx==NIBBLES-1:
    - c_out <= slice carry.
    - ovf <= (A_reg[WIDTH-1]==B_reg[WIDTH-1]) & (slice s[3] != A_reg[WIDTH-1]).
    - idx <= 0; go to DONE.
- State DONE (out_valid=1, in_ready=0):
  - sum, c_out and ovf are held stable.
  - On out_valid & out_ready, go to IDLE. out_valid drops the next cycle.
  - No bypass: a new operand is accepted no earlier than the cycle after the output handshake.
- Latency: the accept edge is cycle 0. The RUN edges are cycles 1..NIBBLES, and out_valid is high from the edge at cycle NIBBLES onward.
- Throughput: with out_ready tied high, at most one operation per NIBBLES+2 cycles.
- Nibble index width is clog2(NIBBLES). No wrap beyond NIBBLES-1.
- Held outputs:
  - sum, c_out and ovf are not cleared on leaving DONE. They hold the last result until the next accept clears sum.
  - Consumers qualify them with out_valid only.
- in_valid while busy is ignored; no state change occurs.
- out_ready while not in DONE is ignored.
- The slice is purely combinational; there is no internal timing path across more than one nibble per cycle.

Test Plan:
- Add, WIDTH=16: a=0x1234, b=0x4321, c_in=0, op_sub=0 -> out_valid 4 cycles after accept; sum=0x5555, c_out=0, ovf=0.
- Full carry ripple across all nibbles: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0. Same operands with c_in=1 -> sum=0x0001, c_out=1.
- Signed overflow: a=0x7FFF, b=0x0001 add -> sum=0x8000, c_out=0, ovf=1. Subtract a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, op_sub=1, c_in=1 (must be ignored) -> sum=0xFFFE, c_out=0, ovf=0.
- Backpressure and busy: hold out_ready=0 for 5 cycles in DONE -> out_valid and sum stable, in_ready=0. Pulse in_valid with other operands during RUN and DONE -> ignored. Raise out_ready -> in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously after 2 RUN cycles -> all outputs at reset values immediately, in_ready=1 after release. A new op 0x0001+0x0001 then returns 0x0002 correctly.
